// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: byte-source request bundle and TX line/status for uart_tx_ctrl
interface uart_tx_ctrl_if;
   logic [7:0] P_Data;
   logic       Data_Valid;
   logic       Parity_Enable;
   logic       Parity_Type;
   logic       TX_OUT;
   logic       Busy;
   logic       Ready;
   modport master (output P_Data, Data_Valid, Parity_Enable, Parity_Type, input TX_OUT, Busy, Ready);
   modport slave (input P_Data, Data_Valid, Parity_Enable, Parity_Type, output TX_OUT, Busy, Ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: one UART frame per accepted byte (start, 8 data LSB first, optional parity, stop); `UART_TX_HOLD_REG_EN adds a one-entry holding register
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input logic clk,
   input logic rst,
   uart_tx_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t r_state, w_state_n;
   logic [2:0] r_cnt, w_cnt_n;
   logic [DATA_WIDTH-1:0] r_data, w_data_n, w_src_data;
   logic r_pen, w_pen_n, w_src_pen;
   logic r_par, w_par_n, w_src_par;
   logic r_tx, r_busy, r_ready;
   logic w_tx_n, w_ready_n;
   logic w_acc, w_in_par, w_load_in, w_load_h, w_load;
   assign w_acc = bus.Data_Valid & r_ready;
   assign w_in_par = bus.Parity_Type ? ~^bus.P_Data : ^bus.P_Data;
   assign bus.TX_OUT = r_tx;
   assign bus.Busy = r_busy;
   assign bus.Ready = r_ready;
`ifdef UART_TX_HOLD_REG_EN
   logic r_h_vld, w_h_vld_n, w_cap;
   logic [DATA_WIDTH-1:0] r_h_data;
   logic r_h_pen, r_h_par;
   assign w_cap = w_acc & (r_state == START || r_state == DATA || r_state == PARITY);
   assign w_load_h = (r_state == STOP) & r_h_vld;
   assign w_h_vld_n = w_cap | (r_h_vld & ~w_load_h);
   assign w_ready_n = ~w_h_vld_n;
   assign w_src_data = w_load_h ? r_h_data : bus.P_Data;
   assign w_src_pen = w_load_h ? r_h_pen : bus.Parity_Enable;
   assign w_src_par = w_load_h ? r_h_par : w_in_par;
   // holding entry: captures a request made mid-frame, released when STOP ends
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_h_vld <= 1'b0;
         r_h_data <= '0;
         r_h_pen <= 1'b0;
         r_h_par <= 1'b0;
      end else begin
         r_h_vld <= w_h_vld_n;
         if (w_cap) begin
            r_h_data <= bus.P_Data;
            r_h_pen <= bus.Parity_Enable;
            r_h_par <= w_in_par;
         end
      end
`else
   assign w_load_h = 1'b0;
   assign w_ready_n = (w_state_n == IDLE);
   assign w_src_data = bus.P_Data;
   assign w_src_pen = bus.Parity_Enable;
   assign w_src_par = w_in_par;
`endif
   // next state and bit counter; STOP chains into START when another byte is waiting
   always_comb begin
      w_state_n = r_state;
      w_cnt_n = r_cnt;
      w_load_in = 1'b0;
      case (r_state)
         IDLE:
            if (w_acc) begin
               w_state_n = START;
               w_load_in = 1'b1;
            end
         START: begin
            w_state_n = DATA;
            w_cnt_n = 3'd0;
         end
         DATA: begin
            w_cnt_n = r_cnt + 3'd1;
            if (r_cnt == 3'(DATA_WIDTH - 1)) w_state_n = r_pen ? PARITY : STOP;
         end
         PARITY: w_state_n = STOP;
         STOP: begin
            w_state_n = IDLE;
`ifdef UART_TX_HOLD_REG_EN
            if (r_h_vld | w_acc) begin
               w_state_n = START;
               w_load_in = ~r_h_vld;
            end
`endif
         end
         default: w_state_n = IDLE;
      endcase
   end
   assign w_load = w_load_in | w_load_h;
   assign w_data_n = w_load ? w_src_data : r_data;
   assign w_pen_n = w_load ? w_src_pen : r_pen;
   assign w_par_n = w_load ? w_src_par : r_par;
   assign w_tx_n = (w_state_n == START) ? 1'b0 : (w_state_n == DATA) ? w_data_n[w_cnt_n] : (w_state_n == PARITY) ? w_par_n : 1'b1;
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else r_state <= w_state_n;
   // frame registers and registered line/status outputs
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_cnt <= 3'd0;
         r_data <= '0;
         r_pen <= 1'b0;
         r_par <= 1'b0;
         r_tx <= 1'b1;
         r_busy <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_cnt <= w_cnt_n;
         r_data <= w_data_n;
         r_pen <= w_pen_n;
         r_par <= w_par_n;
         r_tx <= w_tx_n;
         r_busy <= (w_state_n != IDLE);
         r_ready <= w_ready_n;
      end
endmodule
